// File: rtl/led_fill_drain_checker.sv
// Receive-side monitor for the LED fill/drain pattern bus.
// Tracks the expected fill/drain sequence from the last accepted sample and
// reports lock, per-step mismatches, LED level and completed cycles.
module led_fill_drain_checker #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_CNT_W = 8,
  parameter int unsigned CYC_CNT_W = 8,
  localparam int unsigned LVL_W    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 tick,
  input  logic [WIDTH-1:0]     led_in,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [LVL_W-1:0]     level,
  output logic                 cycle_done,
  output logic [CYC_CNT_W-1:0] cycle_cnt
);

  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [WIDTH-1:0]     ALL_ONES = {WIDTH{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic                 mode_q;
  logic                 locked_d;
  logic                 err_d;
  logic [ERR_CNT_W-1:0] err_cnt_d;
  logic [LVL_W-1:0]     level_d;
  logic                 cycle_done_d;
  logic [CYC_CNT_W-1:0] cycle_cnt_d;
  logic [WIDTH-1:0]     exp_fill;
  logic [WIDTH-1:0]     exp_drain;

  // Expected next frame derived from the last accepted sample
  always_comb begin
    if (mode_q) begin
      exp_fill  = {prev_q[WIDTH-2:0], 1'b1};
      exp_drain = {prev_q[WIDTH-2:0], 1'b0};
    end else begin
      exp_fill  = {1'b1, prev_q[WIDTH-1:1]};
      exp_drain = {1'b0, prev_q[WIDTH-1:1]};
    end
  end

  // Next-state and next-output logic; a mode change overrides any tick
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    locked_d     = locked;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt;
    level_d      = level;
    cycle_done_d = 1'b0;
    cycle_cnt_d  = cycle_cnt;

    if (mode != mode_q) begin
      state_d  = SYNC;
      locked_d = 1'b0;
    end else if (tick) begin
      case (state_q)
        SYNC: begin
          if (led_in == '0) begin
            state_d  = FILL;
            prev_d   = '0;
            locked_d = 1'b1;
            level_d  = '0;
          end
        end
        FILL: begin
          if (led_in == exp_fill) begin
            prev_d  = led_in;
            level_d = level + LVL_W'(1);
            if (led_in == ALL_ONES) state_d = DRAIN;
          end else begin
            state_d  = SYNC;
            locked_d = 1'b0;
            err_d    = 1'b1;
            if (err_cnt != ERR_MAX) err_cnt_d = err_cnt + ERR_CNT_W'(1);
          end
        end
        DRAIN: begin
          if (led_in == exp_drain) begin
            prev_d  = led_in;
            level_d = level - LVL_W'(1);
            if (led_in == '0) begin
              state_d      = FILL;
              cycle_done_d = 1'b1;
              cycle_cnt_d  = cycle_cnt + CYC_CNT_W'(1);
            end
          end else begin
            state_d  = SYNC;
            locked_d = 1'b0;
            err_d    = 1'b1;
            if (err_cnt != ERR_MAX) err_cnt_d = err_cnt + ERR_CNT_W'(1);
          end
        end
        default: begin
          state_d  = SYNC;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; mode_q follows mode during reset so a mode
  // held steady across reset is not seen as a change afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SYNC;
      prev_q     <= '0;
      mode_q     <= mode;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      level      <= '0;
      cycle_done <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      mode_q     <= mode;
      locked     <= locked_d;
      err        <= err_d;
      err_cnt    <= err_cnt_d;
      level      <= level_d;
      cycle_done <= cycle_done_d;
      cycle_cnt  <= cycle_cnt_d;
    end
  end

endmodule
